// File: rtl/pack_frame_store.sv
// Frame-granular packet store: words become visible to the reader only once a whole
// frame is committed; the reader can rewind within its current frame.
module pack_frame_store #(
   parameter int unsigned DW        = 16,
   parameter int unsigned FRAMELOG2 = 3,
   parameter int unsigned DEPTHLOG2 = 12,
   parameter int unsigned STRETCHW  = 26,
   parameter int unsigned DROPW     = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic [DW-1:0]                  in_data,
   input  logic                           in_reset,
   output logic [DW-1:0]                  out_data,
   output logic                           out_valid,
   input  logic                           out_next,
   input  logic                           out_frame_reset,
   output logic                           out_frame_ready,
   output logic [DEPTHLOG2-FRAMELOG2:0]   frames_avail,
   output logic [DROPW-1:0]               drop_cnt,
   input  logic                           drop_clr,
   output logic                           ovf
);

   localparam int unsigned PW = DEPTHLOG2 + 1;
   localparam int unsigned FW = DEPTHLOG2 - FRAMELOG2 + 1;
   localparam logic [PW-1:0] FullDist = {1'b1, {DEPTHLOG2{1'b0}}};

   logic [DW-1:0]       mem_q [2**DEPTHLOG2];
   logic [PW-1:0]       wp_q, wp_d, cwp_q, cwp_d, rp_q, rp_d;
   logic [PW-1:0]       rpb, rpb_d, wp_inc;
   logic                discard_q, discard_d;
   logic                out_valid_q, out_valid_d;
   logic [DW-1:0]       out_data_q;
   logic [FW-1:0]       frames_q, frames_d;
   logic [DROPW-1:0]    drop_q, drop_d;
   logic [STRETCHW-1:0] stretch_q, stretch_d;
   logic                we, ovf_evt, full, rd_take;

   assign rpb    = {rp_q[PW-1:FRAMELOG2], {FRAMELOG2{1'b0}}};
   assign wp_inc = wp_q + PW'(1);
   // Space is reclaimed only a frame at a time so a rewind never sees overwritten data.
   assign full   = (wp_q - rpb) == FullDist;

   always_comb begin
      wp_d      = wp_q;
      cwp_d     = cwp_q;
      discard_d = discard_q;
      we        = 1'b0;
      ovf_evt   = 1'b0;
      if (in_reset) begin
         wp_d      = cwp_q;
         discard_d = 1'b0;
      end else if (in_valid && !discard_q) begin
         if (full) begin
            discard_d = 1'b1;
            ovf_evt   = 1'b1;
         end else begin
            we   = 1'b1;
            wp_d = wp_inc;
            if (wp_inc[FRAMELOG2-1:0] == '0) cwp_d = wp_inc;
         end
      end
   end

   always_comb begin
      rp_d    = rp_q;
      rd_take = 1'b0;
      if (out_frame_reset) begin
         rp_d = rpb;
      end else if (out_next && out_valid_q) begin
         rp_d    = rp_q + PW'(1);
         rd_take = 1'b1;
      end
      rpb_d = {rp_d[PW-1:FRAMELOG2], {FRAMELOG2{1'b0}}};
      // A consumed word forces a one-cycle bubble while the next word is fetched.
      out_valid_d = (rp_d != cwp_d) && !rd_take;
      frames_d    = FW'((cwp_d - rpb_d) >> FRAMELOG2);
   end

   always_comb begin
      drop_d = drop_q;
      if (drop_clr) begin
         drop_d = ovf_evt ? DROPW'(1) : '0;
      end else if (ovf_evt && !(&drop_q)) begin
         drop_d = drop_q + DROPW'(1);
      end
      stretch_d = stretch_q;
      if (ovf_evt) begin
         stretch_d = '1;
      end else if (stretch_q != '0) begin
         stretch_d = stretch_q - STRETCHW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[wp_q[DEPTHLOG2-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q        <= '0;
         cwp_q       <= '0;
         rp_q        <= '0;
         discard_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         frames_q    <= '0;
         drop_q      <= '0;
         stretch_q   <= '0;
      end else begin
         wp_q        <= wp_d;
         cwp_q       <= cwp_d;
         rp_q        <= rp_d;
         discard_q   <= discard_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= mem_q[rp_d[DEPTHLOG2-1:0]];
         frames_q    <= frames_d;
         drop_q      <= drop_d;
         stretch_q   <= stretch_d;
      end
   end

   assign out_data        = out_data_q;
   assign out_valid       = out_valid_q;
   assign frames_avail    = frames_q;
   assign out_frame_ready = frames_q != '0;
   assign drop_cnt        = drop_q;
   assign ovf             = stretch_q != '0;

endmodule

// File: doc/pack_frame_store.md
Name: pack_frame_store

Overview:
- Single-clock, parametrised successor to the packet output buffer.
- Accepts words from the packet processor and holds them until a whole frame (2^FRAMELOG2 words) is committed.
- Presents committed frames to the serial/USB handler with per-frame rewind, overflow-drop accounting and occupancy reporting.
- Sits between the packet builder and the upstream transmit handler.

Parameters:
DW, 16, word width in bits
FRAMELOG2, 3, log2 of words per frame (frame = 8 words)
DEPTHLOG2, 12, log2 of total buffer words; must be > FRAMELOG2
STRETCHW, 26, width of the overflow-indicator stretch counter
DROPW, 8, width of the saturating dropped-frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  in_data valid this cycle
in_data  in  DW  packet word
in_reset  in  1  abort current partial frame, one-cycle strobe
out_data  out  DW  word at read pointer (registered)
out_valid  out  1  out_data holds a committed, unread word
out_next  in  1  consume out_data, one-cycle strobe
out_frame_reset  in  1  rewind read pointer to start of current frame
out_frame_ready  out  1  at least one complete committed frame unread
frames_avail  out  DEPTHLOG2-FRAMELOG2+1  committed frames not yet released
drop_cnt  out  DROPW  frames dropped due to overflow, saturating
drop_clr  in  1  clear drop_cnt
ovf  out  1  stretched overflow indicator

Behaviour:
- Pointers are DEPTHLOG2+1 bits (extra wrap bit):
  - wp: write pointer.
  - cwp: committed write pointer, always frame aligned.
  - rp: read pointer.
  - rpb: rp with low FRAMELOG2 bits zeroed.
- Memory index = pointer[DEPTHLOG2-1:0].
- Reset (rst=0, asynchronous): all pointers 0; discard=0; out_valid=0; out_data=0; out_frame_ready=0; frames_avail=0; drop_cnt=0; ovf=0 (stretch counter 0).
- Full condition: (wp - rpb) == 2^DEPTHLOG2. Rewound data is never overwritten.
- Write, per cycle, in priority order:
  1. in_reset: wp<=cwp; discard<=0; any in_valid word this cycle is dropped.
  2. in_valid & discard: word dropped.
  3. in_valid & full: word dropped; discard<=1; drop_cnt+1 (saturate at all-ones); stretch counter<=all ones.
  4. in_valid: mem[wp]<=in_data; wp<=wp+1. If (wp+1) low FRAMELOG2 bits are 0, cwp<=wp+1 the same cycle (frame commit).
- discard persists until in_reset. Partial frames are never visible to the read side.
- Read side:
  - out_valid/out_data are registered.
  - Next cycle: out_valid<=(rp_next!=cwp_next) and out_data<=mem[rp_next], using the post-update pointers of the current cycle.
  - Commit-to-out_valid latency is 1 cycle.
- out_next while out_valid=1: rp<=rp+1; out_valid deasserts for exactly one cycle (read bubble); peak rate 1 word / 2 cycles.
- out_next while out_valid=0: ignored.
- out_frame_reset: rp<=rpb; has priority over a simultaneous out_next.
- Frame release: when rp increments across a frame boundary, rpb advances and that frame's space is freed the same cycle. Rewind only reaches the current frame.
- frames_avail = (cwp - rpb) >> FRAMELOG2, registered. Includes the partially read current frame.
- out_frame_ready = frames_avail != 0.
- Stretch counter decrements by 1 per cycle when nonzero. ovf = counter != 0. A new overflow reloads it to all ones.
- drop_clr: drop_cnt<=0; a simultaneous overflow yields drop_cnt=1.
- Pointer arithmetic wraps modulo 2^(DEPTHLOG2+1); wrap is transparent.
- Simultaneous frame commit and final-word read of the same region is legal; both take effect.

Test Plan:
- Bench configuration for all scenarios: DEPTHLOG2=5, FRAMELOG2=3, STRETCHW=4 (32 words, 4 frames).
- Reset released, write 7 words 0x0001..0x0007 -> out_valid stays 0, frames_avail=0. Write 8th word 0x0008 -> out_valid=1 next cycle with out_data=0x0001, frames_avail=1.
- Commit one frame, read 3 words, pulse out_frame_reset -> out_data returns to 0x0001. Then read 8 words -> values 0x0001..0x0008 in order, frames_avail=0, out_valid=0.
- Write 5 words, pulse in_reset, write 8 words 0x0100..0x0107 -> read side sees only 0x0100..0x0107. in_reset with in_valid the same cycle drops that word.
- Fill 4 frames with no reads, write a 33rd word -> drop_cnt=1, ovf=1 for exactly 15 cycles. Further writes are dropped until in_reset; committed 32 words read back intact.
- Continuously stream 40 frames with reads interleaved so pointers wrap at least twice -> no data loss, drop_cnt=0, ordering preserved. Assert rst low mid-frame -> all outputs return to reset values immediately.
- drop_cnt at 0xFF plus another overflow -> stays 0xFF. drop_clr together with an overflow -> drop_cnt=1.
